// File: rtl/depth_merge_unit.sv
// depth_merge_unit
//   Depth-test merge stage between UNITS rasterizer channels and port B of the
//   display buffer. Fragments are granted round-robin. The granted fragment's
//   address goes to the buffer the same cycle. The stored {depth,color} comes
//   back one cycle later and is compared. A closer fragment is written back.
//   A clear request sweeps the whole frame with {all-ones depth, CLEAR_COLOR}.
//
// Ports
//   clock, reset         clock and asynchronous active-low reset
//   input_valid/x/y/...  per-unit fragment channels, unit i in slice i
//   written              one-hot accept pulse (combinational, grant cycle)
//   clear_start          request full-buffer clear
//   clear_busy           high during the clear sweep
//   address_x/address_y  buffer port-B address
//   buffer_read_data     stored {depth,color}, valid the cycle after the address
//   write_enable         buffer write strobe
//   buffer_write_data    {depth,color} to write
//   all_complete         idle with no pending fragment and no clear request
//
// Optional build macro DEPTH_MERGE_STATS_EN adds two ports, pass_count and
// reject_count. They are saturating 32-bit event counters.
module depth_merge_unit #(
  parameter int UNITS   = 4,
  parameter int DEPTH_W = 8,
  parameter int COLOR_W = 24,
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [UNITS-1:0]             input_valid,
  input  logic [UNITS*10-1:0]          input_x,
  input  logic [UNITS*10-1:0]          input_y,
  input  logic [UNITS*DEPTH_W-1:0]     input_depth,
  input  logic [UNITS*COLOR_W-1:0]     input_color,
  output logic [UNITS-1:0]             written,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic [9:0]                   address_x,
  output logic [9:0]                   address_y,
  input  logic [DEPTH_W+COLOR_W-1:0]   buffer_read_data,
  output logic                         write_enable,
  output logic [DEPTH_W+COLOR_W-1:0]   buffer_write_data,
  output logic                         all_complete
`ifdef DEPTH_MERGE_STATS_EN
  ,
  output logic [31:0]                  pass_count,
  output logic [31:0]                  reject_count
`endif
);

  localparam int WORD_W = DEPTH_W + COLOR_W;
  localparam int RR_W   = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam logic [10:0] X_LIM  = 11'(X_RES);
  localparam logic [10:0] Y_LIM  = 11'(Y_RES);
  localparam logic [9:0]  X_LAST = 10'(X_RES - 1);
  localparam logic [9:0]  Y_LAST = 10'(Y_RES - 1);
  localparam logic [WORD_W-1:0] CLEAR_WORD = {{DEPTH_W{1'b1}}, CLEAR_COLOR};

  typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [9:0]           frag_x_q, frag_x_d;
  logic [9:0]           frag_y_q, frag_y_d;
  logic [DEPTH_W-1:0]   frag_depth_q, frag_depth_d;
  logic [COLOR_W-1:0]   frag_color_q, frag_color_d;
  logic [9:0]           cx_q, cx_d;
  logic [9:0]           cy_q, cy_d;

  logic                 gnt_found;
  logic [RR_W-1:0]      gnt_idx;
  logic [9:0]           gnt_x, gnt_y;
  logic [DEPTH_W-1:0]   gnt_depth;
  logic [COLOR_W-1:0]   gnt_color;
  logic                 gnt_in_range;
  logic                 arb_cycle;
  logic                 depth_pass, depth_reject, range_drop;
  logic [DEPTH_W-1:0]   stored_depth;
  logic                 unused_rd_color;

  assign stored_depth    = buffer_read_data[WORD_W-1 -: DEPTH_W];
  assign unused_rd_color = ^buffer_read_data[COLOR_W-1:0];

  // Round-robin search: the first valid unit at or after rr, wrapping.
  function automatic logic [RR_W:0] find_grant(input logic [UNITS-1:0] v,
                                               input logic [RR_W-1:0] rr);
    logic [RR_W:0] res;
    int            idx;
    res = '0;
    // Walk offsets from high to low so that the smallest offset wins.
    for (int i = UNITS - 1; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx >= UNITS) idx = idx - UNITS;
      if (v[idx]) res = {1'b1, RR_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [RR_W-1:0] next_rr(input logic [RR_W-1:0] g);
    if (int'(g) == UNITS - 1) return '0;
    return g + 1'b1;
  endfunction

  always_comb begin
    {gnt_found, gnt_idx} = find_grant(input_valid, rr_q);
    gnt_x     = '0;
    gnt_y     = '0;
    gnt_depth = '0;
    gnt_color = '0;
    for (int u = 0; u < UNITS; u++) begin
      if (int'(gnt_idx) == u) begin
        gnt_x     = input_x[10*u +: 10];
        gnt_y     = input_y[10*u +: 10];
        gnt_depth = input_depth[DEPTH_W*u +: DEPTH_W];
        gnt_color = input_color[COLOR_W*u +: COLOR_W];
      end
    end
    gnt_in_range = ({1'b0, gnt_x} < X_LIM) && ({1'b0, gnt_y} < Y_LIM);
  end

  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    frag_x_d          = frag_x_q;
    frag_y_d          = frag_y_q;
    frag_depth_d      = frag_depth_q;
    frag_color_d      = frag_color_q;
    cx_d              = cx_q;
    cy_d              = cy_q;
    written           = '0;
    address_x         = '0;
    address_y         = '0;
    write_enable      = 1'b0;
    buffer_write_data = '0;
    clear_busy        = 1'b0;
    arb_cycle         = 1'b0;
    depth_pass        = 1'b0;
    depth_reject      = 1'b0;
    range_drop        = 1'b0;

    case (state_q)
      ST_IDLE: arb_cycle = 1'b1;
      ST_COMPARE: begin
        if (frag_depth_q < stored_depth) begin
          // The write occupies the port, so no grant is made this cycle.
          depth_pass        = 1'b1;
          write_enable      = 1'b1;
          address_x         = frag_x_q;
          address_y         = frag_y_q;
          buffer_write_data = {frag_depth_q, frag_color_q};
          state_d           = ST_IDLE;
        end else begin
          // The port is free, so this cycle arbitrates as if idle.
          depth_reject = 1'b1;
          arb_cycle    = 1'b1;
        end
      end
      ST_CLEAR: begin
        clear_busy        = 1'b1;
        write_enable      = 1'b1;
        address_x         = cx_q;
        address_y         = cy_q;
        buffer_write_data = CLEAR_WORD;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            cy_d = cy_q + 10'd1;
          end
        end else begin
          cx_d = cx_q + 10'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_cycle) begin
      if (clear_start) begin
        state_d = ST_CLEAR;
      end else if (gnt_found) begin
        written      = UNITS'(1) << gnt_idx;
        address_x    = gnt_x;
        address_y    = gnt_y;
        rr_d         = next_rr(gnt_idx);
        frag_x_d     = gnt_x;
        frag_y_d     = gnt_y;
        frag_depth_d = gnt_depth;
        frag_color_d = gnt_color;
        if (gnt_in_range) begin
          state_d = ST_COMPARE;
        end else begin
          range_drop = 1'b1;
          state_d    = ST_IDLE;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign all_complete = (state_q == ST_IDLE) && (input_valid == '0) && !clear_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      frag_x_q     <= '0;
      frag_y_q     <= '0;
      frag_depth_q <= '0;
      frag_color_q <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      frag_x_q     <= frag_x_d;
      frag_y_q     <= frag_y_d;
      frag_depth_q <= frag_depth_d;
      frag_color_q <= frag_color_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

`ifdef DEPTH_MERGE_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d;
  logic [31:0] rej_cnt_q, rej_cnt_d;
  logic        clear_first;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? '1 : s[31:0];
  endfunction

  // A cycle can carry both a depth reject and an out-of-range drop.
  assign clear_first = (state_q == ST_CLEAR) && (cx_q == '0) && (cy_q == '0);

  always_comb begin
    pass_cnt_d = sat_add(pass_cnt_q, {1'b0, depth_pass});
    rej_cnt_d  = sat_add(rej_cnt_q, {1'b0, depth_reject} + {1'b0, range_drop});
    if (clear_first) begin
      pass_cnt_d = '0;
      rej_cnt_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_cnt_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign pass_count   = pass_cnt_q;
  assign reject_count = rej_cnt_q;
`endif

endmodule
